// File: rtl/lfsr_pkg.sv
// Shared Galois LFSR definitions, so the stream generator and the checker use
// one definition of the step function and of the checker state encoding.
package lfsr_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  // Widths up to 32 bits; bits above n are masked off.
  function automatic logic [31:0] lfsr_step(input logic [31:0] x,
                                            input logic [31:0] poly,
                                            input int          n);
    logic [31:0] mask;
    logic        msb;
    mask = (n >= 32) ? 32'hffff_ffff : ((32'd1 << n) - 32'd1);
    msb  = x[n-1];
    return ((x << 1) ^ (poly & {32{msb}})) & mask;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] cnt_r;

  // Count register: stick at all-ones instead of wrapping.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_r <= {W{1'b0}};
    end else if (i_clr) begin
      cnt_r <= {W{1'b0}};
    end else if (i_inc && (cnt_r != {W{1'b1}})) begin
      cnt_r <= cnt_r + W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign o_cnt = cnt_r;

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side PRBS checker: self-synchronises to a Galois LFSR word stream,
// then flywheels its own prediction and reports mismatches and BER counts.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int         N        = 8,
  parameter logic [N-1:0] POLY   = 8'h9b,
  parameter int         LOCK_CNT = 4,
  parameter int         LOSS_CNT = 4,
  parameter int         CW       = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid,
  input  logic [N-1:0]  i_data,
  input  logic          i_clr_cnt,
  output logic          o_locked,
  output logic          o_err,
  output logic [CW-1:0] o_err_cnt,
  output logic [CW-1:0] o_word_cnt
);

  localparam int MW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
  localparam int LW = (LOSS_CNT < 2) ? 1 : $clog2(LOSS_CNT + 1);

  chk_state_t    state_r, state_s;
  logic [N-1:0]  exp_r, exp_s;
  logic [MW-1:0] match_r, match_s;
  logic [LW-1:0] miss_r, miss_s;
  logic          err_r, locked_r;
  logic          err_inc_s, word_inc_s;
  logic [N-1:0]  step_exp_s, step_data_s;

  assign step_exp_s  = N'(lfsr_step(32'(exp_r), 32'(POLY), N));
  assign step_data_s = N'(lfsr_step(32'(i_data), 32'(POLY), N));

  // State, prediction and registered status outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r  <= SEARCH;
      exp_r    <= {N{1'b0}};
      match_r  <= {MW{1'b0}};
      miss_r   <= {LW{1'b0}};
      err_r    <= 1'b0;
      locked_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      exp_r    <= exp_s;
      match_r  <= match_s;
      miss_r   <= miss_s;
      err_r    <= err_inc_s;
      locked_r <= (state_s == LOCKED);
    end
  end

  // Next-state logic: seed from data while acquiring, flywheel once locked.
  always_comb begin
    state_s    = state_r;
    exp_s      = exp_r;
    match_s    = match_r;
    miss_s     = miss_r;
    err_inc_s  = 1'b0;
    word_inc_s = 1'b0;
    if (i_valid) begin
      case (state_r)
        SEARCH: begin
          if (i_data != {N{1'b0}}) begin
            exp_s   = step_data_s;
            match_s = {MW{1'b0}};
            state_s = VERIFY;
          end else begin
            state_s = SEARCH;
          end
        end
        VERIFY: begin
          if (i_data == exp_r) begin
            exp_s = step_data_s;
            if ((match_r + MW'(1)) == MW'(LOCK_CNT)) begin
              state_s = LOCKED;
              match_s = {MW{1'b0}};
              miss_s  = {LW{1'b0}};
            end else begin
              match_s = match_r + MW'(1);
            end
          end else if (i_data != {N{1'b0}}) begin
            exp_s   = step_data_s;
            match_s = {MW{1'b0}};
          end else begin
            state_s = SEARCH;
            match_s = {MW{1'b0}};
          end
        end
        LOCKED: begin
          exp_s      = step_exp_s;
          word_inc_s = 1'b1;
          if (i_data == exp_r) begin
            miss_s = {LW{1'b0}};
          end else begin
            err_inc_s = 1'b1;
            if ((miss_r + LW'(1)) == LW'(LOSS_CNT)) begin
              state_s = SEARCH;
              miss_s  = {LW{1'b0}};
            end else begin
              miss_s = miss_r + LW'(1);
            end
          end
        end
        default: begin
          state_s = SEARCH;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  sat_counter #(.W(CW)) u_err_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (err_inc_s),
    .i_clr (i_clr_cnt),
    .o_cnt (o_err_cnt)
  );

  sat_counter #(.W(CW)) u_word_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (word_inc_s),
    .i_clr (i_clr_cnt),
    .o_cnt (o_word_cnt)
  );

  assign o_err    = err_r;
  assign o_locked = locked_r;

endmodule
